edge_event_arbiter: RTL and testbench



---
 rtl/edge_event_if.sv | 36 +++
 rtl/edge_event_arbiter.sv | 152 +++++++++++++++
 tb/tb_edge_event_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_event_if.sv
// Consumer-side event handshake of edge_event_arbiter.
// The evt_time field and TS_W exist only when EDGE_EVENT_TIMESTAMP_EN is defined.
interface edge_event_if #(
   parameter int CH_W = 2
`ifdef EDGE_EVENT_TIMESTAMP_EN
   , parameter int TS_W = 16
`endif
);
   logic            evt_valid;
   logic            evt_ready;
   logic [CH_W-1:0] evt_ch;
   logic            evt_rising;
`ifdef EDGE_EVENT_TIMESTAMP_EN
   logic [TS_W-1:0] evt_time;
`endif

   modport master (
      input  evt_ready,
      output evt_valid,
      output evt_ch,
      output evt_rising
`ifdef EDGE_EVENT_TIMESTAMP_EN
      , output evt_time
`endif
   );

   modport slave (
      output evt_ready,
      input  evt_valid,
      input  evt_ch,
      input  evt_rising
`ifdef EDGE_EVENT_TIMESTAMP_EN
      , input  evt_time
`endif
   );
endinterface

// File: rtl/edge_event_arbiter.sv
// Latches per-channel edge pulses as pending events, grants them round-robin into a show-ahead FIFO.
// Optional macro EDGE_EVENT_TIMESTAMP_EN adds a free-running timestamp carried with each event.
module edge_event_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2,
   parameter int DEPTH  = 8,
   parameter int PTR_W  = 3,
   parameter int TS_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] pos_pulse,
   input  logic [NUM_CH-1:0] neg_pulse,
   input  logic [NUM_CH-1:0] ch_enable,
   input  logic              clear_ovf,
   edge_event_if.master      evt,
   output logic [PTR_W:0]    evt_count,
   output logic              overflow
);

`ifdef EDGE_EVENT_TIMESTAMP_EN
   localparam int ENT_W = CH_W + 1 + TS_W;
`else
   localparam int ENT_W = CH_W + 1;
`endif
   localparam int R_BIT = ENT_W - 1 - CH_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   if (NUM_CH < 2 || NUM_CH > 16 || (1 << CH_W) < NUM_CH ||
       DEPTH != (1 << PTR_W) || TS_W < 1) begin : g_param_check
      $error("edge_event_arbiter: inconsistent parameters");
   end

   logic [NUM_CH-1:0] pend_r, pend_f, last_edge;
   logic [NUM_CH-1:0] set_r, set_f, clr_r, clr_f, drop_r, drop_f;
   logic [NUM_CH-1:0] gnt_oh;
   logic [CH_W-1:0]   rr_ptr, gnt_ch;
   logic              found, gnt_rising, grant, pop, full, drop;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [ENT_W-1:0]  mem [DEPTH];
   logic [ENT_W-1:0]  head, entry;

`ifdef EDGE_EVENT_TIMESTAMP_EN
   logic [TS_W-1:0] ts_cnt, gnt_time;
   logic [TS_W-1:0] ts_r [NUM_CH];
   logic [TS_W-1:0] ts_f [NUM_CH];
`endif

   // Round-robin search: first pass covers rr_ptr..NUM_CH-1, second pass wraps to 0.
   always_comb begin
      found      = 1'b0;
      gnt_ch     = '0;
      gnt_rising = 1'b0;
      gnt_oh     = '0;
`ifdef EDGE_EVENT_TIMESTAMP_EN
      gnt_time   = '0;
`endif
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && (pend_r[i] || pend_f[i]) && (pass == 1 || CH_W'(i) >= rr_ptr)) begin
               found      = 1'b1;
               gnt_ch     = CH_W'(i);
               gnt_oh[i]  = 1'b1;
               // With both edges pending, the one opposite the last delivered edge goes first.
               gnt_rising = pend_r[i] && !(pend_f[i] && last_edge[i]);
`ifdef EDGE_EVENT_TIMESTAMP_EN
               gnt_time   = gnt_rising ? ts_r[i] : ts_f[i];
`endif
            end
         end
      end
   end

   assign full   = (evt_count == FULL_CNT);
   assign pop    = evt.evt_valid && evt.evt_ready;
   assign grant  = found && (!full || pop);
   assign set_r  = pos_pulse & ch_enable;
   assign set_f  = neg_pulse & ch_enable;
   assign clr_r  = gnt_oh & {NUM_CH{grant && gnt_rising}};
   assign clr_f  = gnt_oh & {NUM_CH{grant && !gnt_rising}};
   // A re-pulse on a bit that is being granted this cycle simply re-arms it.
   assign drop_r = set_r & pend_r & ~clr_r;
   assign drop_f = set_f & pend_f & ~clr_f;
   assign drop   = |{drop_r, drop_f};

`ifdef EDGE_EVENT_TIMESTAMP_EN
   assign entry = {gnt_ch, gnt_rising, gnt_time};
`else
   assign entry = {gnt_ch, gnt_rising};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_r    <= '0;
         pend_f    <= '0;
         last_edge <= '0;
         rr_ptr    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         evt_count <= '0;
         overflow  <= 1'b0;
`ifdef EDGE_EVENT_TIMESTAMP_EN
         ts_cnt    <= '0;
`endif
      end else begin
         pend_r <= (pend_r & ~clr_r) | set_r;
         pend_f <= (pend_f & ~clr_f) | set_f;
         if (grant) begin
            last_edge <= (last_edge & ~gnt_oh) | (gnt_oh & {NUM_CH{gnt_rising}});
            rr_ptr    <= (gnt_ch == CH_W'(NUM_CH-1)) ? '0 : gnt_ch + CH_W'(1);
            wr_ptr    <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({grant, pop})
            2'b10:   evt_count <= evt_count + (PTR_W+1)'(1);
            2'b01:   evt_count <= evt_count - (PTR_W+1)'(1);
            default: evt_count <= evt_count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
`ifdef EDGE_EVENT_TIMESTAMP_EN
         ts_cnt <= ts_cnt + TS_W'(1);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (grant)
         mem[wr_ptr] <= entry;
`ifdef EDGE_EVENT_TIMESTAMP_EN
      for (int c = 0; c < NUM_CH; c++) begin
         if (set_r[c] && !drop_r[c])
            ts_r[c] <= ts_cnt;
         if (set_f[c] && !drop_f[c])
            ts_f[c] <= ts_cnt;
      end
`endif
   end

   // Show-ahead head; fields are forced to zero while the queue is empty.
   assign head           = mem[rd_ptr];
   assign evt.evt_valid  = (evt_count != '0);
   assign evt.evt_ch     = evt.evt_valid ? head[ENT_W-1 -: CH_W] : '0;
   assign evt.evt_rising = evt.evt_valid && head[R_BIT];
`ifdef EDGE_EVENT_TIMESTAMP_EN
   assign evt.evt_time   = evt.evt_valid ? head[TS_W-1:0] : '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: latency, round-robin, back-pressure, overflow, edge order, reset.
module tb_edge_event_arbiter;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam int DEPTH  = 8;
   localparam int PTR_W  = 3;
   localparam int TS_W   = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] pos_pulse, neg_pulse, ch_enable;
   logic              clear_ovf;
   logic [PTR_W:0]    evt_count;
   logic              overflow;

   int n_cmp = 0;
   int n_mis = 0;

   int unsigned seq_ch [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
   int unsigned seq_r  [9] = '{0, 1, 0, 1, 1, 0, 1, 0, 1};

`ifdef EDGE_EVENT_TIMESTAMP_EN
   edge_event_if #(.CH_W(CH_W), .TS_W(TS_W)) bus ();
`else
   edge_event_if #(.CH_W(CH_W)) bus ();
`endif

   edge_event_arbiter #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .TS_W(TS_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pos_pulse (pos_pulse),
      .neg_pulse (neg_pulse),
      .ch_enable (ch_enable),
      .clear_ovf (clear_ovf),
      .evt       (bus),
      .evt_count (evt_count),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_head(input string tag, input int unsigned ch, input int unsigned rising);
      check({tag, "_valid"},  32'(bus.evt_valid),  1);
      check({tag, "_ch"},     32'(bus.evt_ch),     ch);
      check({tag, "_rising"}, 32'(bus.evt_rising), rising);
   endtask

   task automatic pulse(input int unsigned ch, input int unsigned rising);
      if (rising != 0) pos_pulse = NUM_CH'(1 << ch);
      else             neg_pulse = NUM_CH'(1 << ch);
      tick();
      pos_pulse = '0;
      neg_pulse = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      reset         = 1'b1;
      pos_pulse     = '0;
      neg_pulse     = '0;
      ch_enable     = '1;
      clear_ovf     = 1'b0;
      bus.evt_ready = 1'b0;
      tick();
      tick();
      check("rst_valid",  32'(bus.evt_valid),  0);
      check("rst_count",  32'(evt_count),      0);
      check("rst_ovf",    32'(overflow),       0);
      check("rst_ch",     32'(bus.evt_ch),     0);
      check("rst_rising", 32'(bus.evt_rising), 0);
      reset = 1'b0;
      tick();

      // single pulse: visible two edges after the pulse, gone after one accept
      bus.evt_ready = 1'b1;
      pulse(2, 1);
      check("lat_early_valid", 32'(bus.evt_valid), 0);
      tick();
      check_head("single", 2, 1);
      tick();
      check("single_drained", 32'(bus.evt_valid), 0);
      check("single_ovf",     32'(overflow),      0);

      // round-robin from rr_ptr=0
      do_reset();
      bus.evt_ready = 1'b1;
      pos_pulse = 4'b1111;
      tick();
      pos_pulse = '0;
      tick();
      check_head("rr0", 0, 1);
      tick();
      check_head("rr1", 1, 1);
      tick();
      check_head("rr2", 2, 1);
      tick();
      check_head("rr3", 3, 1);
      tick();
      check("rr_empty", 32'(bus.evt_valid), 0);
      pos_pulse = 4'b1001;
      tick();
      pos_pulse = '0;
      tick();
      check_head("wrap_first", 0, 1);
      tick();
      check_head("wrap_second", 3, 1);
      tick();
      check("wrap_empty", 32'(bus.evt_valid), 0);

      // back-pressure: 8 fill the FIFO, the 9th waits as a pending bit
      bus.evt_ready = 1'b0;
      for (int k = 0; k < 9; k++) pulse(seq_ch[k], seq_r[k]);
      tick();
      check("bp_full_count", 32'(evt_count), DEPTH);
      check_head("bp_head_stall", seq_ch[0], seq_r[0]);
      bus.evt_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         check_head($sformatf("bp_evt%0d", k), seq_ch[k], seq_r[k]);
         tick();
      end
      check("bp_empty", 32'(bus.evt_valid), 0);
      check("bp_count", 32'(evt_count),     0);
      check("bp_ovf",   32'(overflow),      0);

      // overflow: re-pulse on a still-pending bit while full
      bus.evt_ready = 1'b0;
      for (int k = 0; k < 8; k++) pulse(seq_ch[k], seq_r[k]);
      tick();
      check("ovf_full_count", 32'(evt_count), DEPTH);
      pulse(1, 0);
      check("ovf_first_pulse", 32'(overflow), 0);
      tick();
      tick();
      pulse(1, 0);
      check("ovf_set", 32'(overflow), 1);
      clear_ovf = 1'b1;
      neg_pulse = 4'b0010;
      tick();
      clear_ovf = 1'b0;
      neg_pulse = '0;
      check("ovf_set_wins", 32'(overflow), 1);
      clear_ovf = 1'b1;
      tick();
      clear_ovf = 1'b0;
      check("ovf_cleared", 32'(overflow), 0);
      bus.evt_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check_head($sformatf("ovf_evt%0d", k), seq_ch[k], seq_r[k]);
         tick();
      end
      check_head("ovf_ch1_fall", 1, 0);
      tick();
      check("ovf_empty", 32'(bus.evt_valid), 0);

      // edge ordering: last_edge rising, both pending -> falling first
      pulse(3, 1);
      tick();
      check_head("eo_setup", 3, 1);
      tick();
      check("eo_setup_empty", 32'(bus.evt_valid), 0);
      pos_pulse = 4'b1000;
      neg_pulse = 4'b1000;
      tick();
      pos_pulse = '0;
      neg_pulse = '0;
      tick();
      check_head("eo_first", 3, 0);
      tick();
      check_head("eo_second", 3, 1);
      tick();
      check("eo_empty", 32'(bus.evt_valid), 0);

      // disabled channel
      ch_enable = 4'b0111;
      pulse(3, 1);
      tick();
      tick();
      check("dis_valid", 32'(bus.evt_valid), 0);
      check("dis_count", 32'(evt_count),     0);
      ch_enable = '1;

      // asynchronous reset with events queued
      bus.evt_ready = 1'b0;
      pulse(0, 1);
      pulse(1, 1);
      pulse(2, 1);
      pulse(0, 0);
      pulse(1, 0);
      tick();
      tick();
      check("mid_count", 32'(evt_count), 5);
      #2;
      reset = 1'b1;
      #1;
      check("async_valid", 32'(bus.evt_valid), 0);
      check("async_count", 32'(evt_count),     0);
      #2;
      reset = 1'b0;
      bus.evt_ready = 1'b1;
      tick();
      tick();
      tick();
      check("post_rst_valid", 32'(bus.evt_valid), 0);
      check("post_rst_count", 32'(evt_count),     0);
      check("post_rst_ovf",   32'(overflow),      0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
